sy_ppl_wbk: RTL and testbench



---
 rtl/sy_pkg.sv | 33 +++
 rtl/sy_ppl_wbk_fifo.sv | 72 +++++++
 rtl/sy_ppl_wbk.sv | 165 ++++++++++++++++
 tb/tb_sy_ppl_wbk.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sy_pkg.sv
// Shared core types and constants used by the writeback stage.
package sy_pkg;

    // GPR data width and register-file geometry.
    localparam int unsigned DWTH      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NUM_REGS  = 32;

    // Register-file write request as carried through the MDU result buffer.
    typedef struct packed {
        logic [REG_IDX_W-1:0] idx;
        logic [DWTH-1:0]      data;
    } wbk_req_t;

    // Owner of the single register-file write slot in a given cycle.
    typedef enum logic [1:0] {
        SlotNone = 2'd0,
        SlotAlu  = 2'd1,
        SlotMdu  = 2'd2
    } slot_sel_e;

    // One-hot decode of a register index; x0 maps to all-zeros so it can
    // never be marked busy or cleared.
    function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [REG_IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] vec;
        vec = '0;
        if (idx != '0) begin
            vec[idx] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/sy_ppl_wbk_fifo.sv
// Generic synchronous FIFO. Only pointers and count are reset; storage is not.
module sy_ppl_wbk_fifo #(
    parameter int unsigned DEPTH = 2,   // power of two, >= 2
    parameter type         T     = logic
) (
    input  logic clk_i,
    input  logic rst_i,        // synchronous, active-low
    input  logic push_i,
    input  T     push_data_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output T     head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Requests that would overflow or underflow are ignored.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Next-state for pointers and occupancy; pointers wrap at DEPTH by width.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage, written on accepted push only.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/sy_ppl_wbk.sv
// Writeback stage: arbitrates the single register-file write port between the
// never-stalled ALU and the buffered MDU, and tracks pending MDU destinations.
module sy_ppl_wbk
    import sy_pkg::*;
#(
    parameter int unsigned MDU_FIFO_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,                 // synchronous, active-low

    input  logic                 alu_wbk__rdst_en_i,
    input  logic [REG_IDX_W-1:0] alu_wbk__rdst_idx_i,
    input  logic [DWTH-1:0]      alu_wbk__rdst_data_i,

    input  logic                 mdu_wbk__vld_i,
    output logic                 wbk_mdu__rdy_o,
    input  logic [REG_IDX_W-1:0] mdu_wbk__rdst_idx_i,
    input  logic [DWTH-1:0]      mdu_wbk__rdst_data_i,

    input  logic                 dec_wbk__mdu_issue_i,
    input  logic [REG_IDX_W-1:0] dec_wbk__mdu_rd_idx_i,
    input  logic [REG_IDX_W-1:0] dec_wbk__rs1_idx_i,
    input  logic [REG_IDX_W-1:0] dec_wbk__rs2_idx_i,
    output logic                 wbk_dec__rs_busy_o,

    output logic                 wbk_reg__rdst_en_o,
    output logic [REG_IDX_W-1:0] wbk_reg__rdst_idx_o,
    output logic [DWTH-1:0]      wbk_reg__rdst_data_o
);

    wbk_req_t             mdu_req;
    wbk_req_t             fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    slot_sel_e            slot_sel;

    logic                 rdst_en_q,   rdst_en_d;
    logic [REG_IDX_W-1:0] rdst_idx_q,  rdst_idx_d;
    logic [DWTH-1:0]      rdst_data_q, rdst_data_d;

    logic [NUM_REGS-1:0]  busy_q, busy_d;
    logic [NUM_REGS-1:0]  busy_set;
    logic [NUM_REGS-1:0]  busy_clr;

    // ------------------------------------------------------------------
    // MDU result buffer
    // ------------------------------------------------------------------
    assign mdu_req.idx  = mdu_wbk__rdst_idx_i;
    assign mdu_req.data = mdu_wbk__rdst_data_i;

    // Ready depends only on current occupancy; a full buffer never accepts,
    // even if the head is popped in the same cycle.
    assign wbk_mdu__rdy_o = ~fifo_full;
    assign fifo_push      = mdu_wbk__vld_i & ~fifo_full;

    sy_ppl_wbk_fifo #(
        .DEPTH (MDU_FIFO_DEPTH),
        .T     (wbk_req_t)
    ) u_mdu_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (fifo_push),
        .push_data_i (mdu_req),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    // ------------------------------------------------------------------
    // Slot arbitration and output-register next state
    // ------------------------------------------------------------------
    // ALU to a real register wins; ALU to x0 is dropped and frees the slot.
    always_comb begin
        slot_sel = SlotNone;
        if (alu_wbk__rdst_en_i && (alu_wbk__rdst_idx_i != '0)) begin
            slot_sel = SlotAlu;
        end else if (!fifo_empty) begin
            slot_sel = SlotMdu;
        end
    end

    assign fifo_pop = (slot_sel == SlotMdu);

    // Load the winner; a popped x0 entry is consumed without a write.
    always_comb begin
        rdst_en_d   = 1'b0;
        rdst_idx_d  = rdst_idx_q;
        rdst_data_d = rdst_data_q;
        unique case (slot_sel)
            SlotAlu: begin
                rdst_en_d   = 1'b1;
                rdst_idx_d  = alu_wbk__rdst_idx_i;
                rdst_data_d = alu_wbk__rdst_data_i;
            end
            SlotMdu: begin
                if (fifo_head.idx != '0) begin
                    rdst_en_d   = 1'b1;
                    rdst_idx_d  = fifo_head.idx;
                    rdst_data_d = fifo_head.data;
                end
            end
            default: ;
        endcase
    end

    // Register-file write port register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rdst_en_q   <= 1'b0;
            rdst_idx_q  <= '0;
            rdst_data_q <= '0;
        end else begin
            rdst_en_q   <= rdst_en_d;
            rdst_idx_q  <= rdst_idx_d;
            rdst_data_q <= rdst_data_d;
        end
    end

    assign wbk_reg__rdst_en_o   = rdst_en_q;
    assign wbk_reg__rdst_idx_o  = rdst_idx_q;
    assign wbk_reg__rdst_data_o = rdst_data_q;

    // ------------------------------------------------------------------
    // Busy scoreboard
    // ------------------------------------------------------------------
    // Clear when the MDU entry enters the output register; the regfile bypass
    // covers the following cycle. A same-edge new issue re-sets the bit.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (dec_wbk__mdu_issue_i) begin
            busy_set = idx_onehot(dec_wbk__mdu_rd_idx_i);
        end
        if (slot_sel == SlotMdu) begin
            busy_clr = idx_onehot(fifo_head.idx);
        end
        busy_d = (busy_q & ~busy_clr) | busy_set;
    end

    // Busy vector register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Hazard query straight off the registered scoreboard.
    assign wbk_dec__rs_busy_o =
        ((dec_wbk__rs1_idx_i != '0) & busy_q[dec_wbk__rs1_idx_i]) |
        ((dec_wbk__rs2_idx_i != '0) & busy_q[dec_wbk__rs2_idx_i]);

    // Decode must not issue to a destination that is still pending, unless
    // that destination is being retired on this very edge.
    a_no_busy_reissue : assert property (
        @(posedge clk_i) disable iff (!rst_i)
        (dec_wbk__mdu_issue_i && (dec_wbk__mdu_rd_idx_i != '0)) |->
            (!busy_q[dec_wbk__mdu_rd_idx_i] || busy_clr[dec_wbk__mdu_rd_idx_i])
    );

endmodule

// File: tb/tb_sy_ppl_wbk.sv
// Directed self-checking bench for the writeback stage.
module tb_sy_ppl_wbk;
    import sy_pkg::*;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 alu_en;
    logic [REG_IDX_W-1:0] alu_idx;
    logic [DWTH-1:0]      alu_data;
    logic                 mdu_vld;
    logic                 mdu_rdy;
    logic [REG_IDX_W-1:0] mdu_idx;
    logic [DWTH-1:0]      mdu_data;
    logic                 issue;
    logic [REG_IDX_W-1:0] issue_rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic                 rs_busy;
    logic                 wr_en;
    logic [REG_IDX_W-1:0] wr_idx;
    logic [DWTH-1:0]      wr_data;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    sy_ppl_wbk #(
        .MDU_FIFO_DEPTH (2)
    ) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .alu_wbk__rdst_en_i    (alu_en),
        .alu_wbk__rdst_idx_i   (alu_idx),
        .alu_wbk__rdst_data_i  (alu_data),
        .mdu_wbk__vld_i        (mdu_vld),
        .wbk_mdu__rdy_o        (mdu_rdy),
        .mdu_wbk__rdst_idx_i   (mdu_idx),
        .mdu_wbk__rdst_data_i  (mdu_data),
        .dec_wbk__mdu_issue_i  (issue),
        .dec_wbk__mdu_rd_idx_i (issue_rd),
        .dec_wbk__rs1_idx_i    (rs1),
        .dec_wbk__rs2_idx_i    (rs2),
        .wbk_dec__rs_busy_o    (rs_busy),
        .wbk_reg__rdst_en_o    (wr_en),
        .wbk_reg__rdst_idx_o   (wr_idx),
        .wbk_reg__rdst_data_o  (wr_data)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        alu_en   = 1'b0;
        alu_idx  = '0;
        alu_data = '0;
        mdu_vld  = 1'b0;
        mdu_idx  = '0;
        mdu_data = '0;
        issue    = 1'b0;
        issue_rd = '0;
        rs1      = '0;
        rs2      = '0;
    endtask

    task automatic check_wr(input string tag, input logic ee, input logic [4:0] ei,
                            input logic [31:0] ed);
        check_eq({tag, ".en"},   64'(wr_en),   64'(ee));
        check_eq({tag, ".idx"},  64'(wr_idx),  64'(ei));
        check_eq({tag, ".data"}, 64'(wr_data), 64'(ed));
    endtask

    // One cycle: drive ALU/MDU, check ready before the edge, check write port after.
    task automatic cyc(input string tag,
                       input logic ae, input logic [4:0] ai, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mi, input logic [31:0] md,
                       input logic er,
                       input logic ee, input logic [4:0] ei, input logic [31:0] ed);
        alu_en   = ae;
        alu_idx  = ai;
        alu_data = ad;
        mdu_vld  = mv;
        mdu_idx  = mi;
        mdu_data = md;
        settle();
        check_eq({tag, ".rdy"}, 64'(mdu_rdy), 64'(er));
        step();
        check_wr(tag, ee, ei, ed);
    endtask

    initial begin
        idle();
        rst_i = 1'b0;
        step();
        step();
        // Reset state
        check_wr("rst", 1'b0, 5'd0, 32'h0);
        check_eq("rst.rdy", 64'(mdu_rdy), 64'h1);
        check_eq("rst.busy", 64'(rs_busy), 64'h0);
        rst_i = 1'b1;

        // T1 ALU only
        alu_en = 1'b1; alu_idx = 5'd5; alu_data = 32'hA5;
        step();
        idle();
        check_wr("t1.wr", 1'b1, 5'd5, 32'hA5);
        step();
        check_wr("t1.hold", 1'b0, 5'd5, 32'hA5);

        // T2 MDU only
        issue = 1'b1; issue_rd = 5'd7;
        step();
        issue = 1'b0; rs1 = 5'd7;
        settle();
        check_eq("t2.busy_issued", 64'(rs_busy), 64'h1);
        mdu_vld = 1'b1; mdu_idx = 5'd7; mdu_data = 32'h1234;
        settle();
        check_eq("t2.rdy", 64'(mdu_rdy), 64'h1);
        step();
        mdu_vld = 1'b0;
        check_eq("t2.en_after_push", 64'(wr_en), 64'h0);
        check_eq("t2.busy_after_push", 64'(rs_busy), 64'h1);
        step();
        check_wr("t2.wr", 1'b1, 5'd7, 32'h1234);
        check_eq("t2.busy_cleared", 64'(rs_busy), 64'h0);
        idle();

        // T3 contention: 4 ALU writes, 3 MDU offers, depth 2
        cyc("t3.c0", 1'b1, 5'd10, 32'h100, 1'b1, 5'd11, 32'h11, 1'b1, 1'b1, 5'd10, 32'h100);
        cyc("t3.c1", 1'b1, 5'd12, 32'h101, 1'b1, 5'd13, 32'h13, 1'b1, 1'b1, 5'd12, 32'h101);
        cyc("t3.c2", 1'b1, 5'd14, 32'h102, 1'b1, 5'd15, 32'h15, 1'b0, 1'b1, 5'd14, 32'h102);
        cyc("t3.c3", 1'b1, 5'd16, 32'h103, 1'b1, 5'd15, 32'h15, 1'b0, 1'b1, 5'd16, 32'h103);
        cyc("t3.c4", 1'b0, 5'd0,  32'h0,   1'b1, 5'd15, 32'h15, 1'b0, 1'b1, 5'd11, 32'h11);
        cyc("t3.c5", 1'b0, 5'd0,  32'h0,   1'b1, 5'd15, 32'h15, 1'b1, 1'b1, 5'd13, 32'h13);
        cyc("t3.c6", 1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 5'd15, 32'h15);
        cyc("t3.c7", 1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd15, 32'h15);

        // T4 x0 handling
        cyc("t4.c0", 1'b1, 5'd20, 32'h200,  1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 5'd20, 32'h200);
        cyc("t4.c1", 1'b1, 5'd0,  32'hDEAD, 1'b1, 5'd0, 32'h77, 1'b1, 1'b1, 5'd9,  32'h99);
        cyc("t4.c2", 1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 5'd9,  32'h99);
        cyc("t4.c3", 1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 5'd9,  32'h99);

        // T5 set/clear collision on x3
        idle();
        issue = 1'b1; issue_rd = 5'd3;
        step();
        issue = 1'b0;
        mdu_vld = 1'b1; mdu_idx = 5'd3; mdu_data = 32'h333;
        step();
        mdu_vld = 1'b0;
        issue = 1'b1; issue_rd = 5'd3; rs1 = 5'd3;
        settle();
        check_eq("t5.busy_before", 64'(rs_busy), 64'h1);
        step();
        issue = 1'b0;
        check_wr("t5.wr", 1'b1, 5'd3, 32'h333);
        settle();
        check_eq("t5.busy_rs1", 64'(rs_busy), 64'h1);
        rs1 = 5'd0; rs2 = 5'd3;
        settle();
        check_eq("t5.busy_rs2", 64'(rs_busy), 64'h1);
        rs2 = 5'd0;
        settle();
        check_eq("t5.busy_x0", 64'(rs_busy), 64'h0);

        // T6 reset with full FIFO and busy = {x7, x3}
        issue = 1'b1; issue_rd = 5'd7;
        step();
        issue = 1'b0;
        cyc("t6.c0", 1'b1, 5'd1, 32'h1, 1'b1, 5'd3, 32'hA3, 1'b1, 1'b1, 5'd1, 32'h1);
        cyc("t6.c1", 1'b1, 5'd2, 32'h2, 1'b1, 5'd7, 32'hA7, 1'b1, 1'b1, 5'd2, 32'h2);
        alu_en = 1'b1; alu_idx = 5'd4; alu_data = 32'h4;
        mdu_vld = 1'b1; mdu_idx = 5'd9; mdu_data = 32'h9;
        rs1 = 5'd3; rs2 = 5'd7;
        rst_i = 1'b0;
        settle();
        check_eq("t6.rdy_full", 64'(mdu_rdy), 64'h0);
        check_eq("t6.busy_pre", 64'(rs_busy), 64'h1);
        step();
        rst_i = 1'b1;
        alu_en = 1'b0; mdu_vld = 1'b0;
        check_wr("t6.rst", 1'b0, 5'd0, 32'h0);
        settle();
        check_eq("t6.rdy", 64'(mdu_rdy), 64'h1);
        check_eq("t6.busy", 64'(rs_busy), 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t6.no_stale", 64'(wr_en), 64'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
